// File: rtl/shaper_filter.sv
// shaper_filter: trapezoidal or difference shaping filter with a per-pulse peak detector.
// Latency: 2 clk from an accepted sample to output_valid; peak_valid 1 clk after the ending output.
// Backpressure: none; input_valid gaps stall the pipeline, and a sample on a cfg_load cycle is dropped.
//
// Ports: clk, reset (synchronous, active-high); input_data/input_valid sample stream;
// cfg_load/cfg_k/cfg_l/cfg_mode run-time configuration; threshold signed peak level;
// output_data/output_valid shaped stream; peak_valid/peak_amp/peak_time pulse record;
// cfg_error sticky flag for a rejected configuration.
module shaper_filter #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 32,
  parameter int K_DEF  = 4,
  parameter int L_DEF  = 8,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int OUT_W = DATA_W + CW,
  localparam int TW    = CW + 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       input_data,
  input  logic                    input_valid,
  input  logic                    cfg_load,
  input  logic [CW-1:0]           cfg_k,
  input  logic [CW-1:0]           cfg_l,
  input  logic                    cfg_mode,
  input  logic signed [OUT_W-1:0] threshold,
  output logic signed [OUT_W-1:0] output_data,
  output logic                    output_valid,
  output logic                    peak_valid,
  output logic signed [OUT_W-1:0] peak_amp,
  output logic [TW-1:0]           peak_time,
  output logic                    cfg_error
);
  localparam int AW = CW - 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    BELOW  = 2'd1,
    ABOVE  = 2'd2
  } state_t;

  state_t state;

  // Active configuration
  logic [CW-1:0] k_r;
  logic [CW-1:0] l_r;
  logic          mode_r;
  logic [CW-1:0] kl_sum;

  // Accepted samples since the last clear; freezes at K+L once warm-up ends
  logic [CW-1:0] warm_cnt;

  logic [CW:0] cfg_sum;
  logic        cfg_ok;
  logic        cfg_accept;
  logic        sample_ok;

  assign cfg_sum    = {1'b0, cfg_k} + {1'b0, cfg_l};
  assign cfg_ok     = (cfg_k != '0) && (cfg_k <= cfg_l) && (cfg_sum <= DEPTH_C);
  assign cfg_accept = cfg_load && cfg_ok;
  assign sample_ok  = input_valid && !cfg_load;
  assign kl_sum     = k_r + l_r;

  // ---------------------------------------------------------------------------
  // Delay line
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     addr_k;
  logic [AW-1:0]     addr_l;
  logic [AW-1:0]     addr_kl;

  // K+L may equal DEPTH; the address then wraps onto the slot being written,
  // whose pre-write content is exactly x(n-DEPTH).
  assign addr_k  = wr_ptr - k_r[AW-1:0];
  assign addr_l  = wr_ptr - l_r[AW-1:0];
  assign addr_kl = wr_ptr - kl_sum[AW-1:0];

  always_ff @(posedge clk) begin
    if (sample_ok) begin
      mem[wr_ptr] <= input_data;
    end
  end

  // A tap reaching back past the last clear reads as zero, so the memory
  // itself never needs wiping. After warm-up every tap is in range.
  logic signed [OUT_W-1:0] x0;
  logic signed [OUT_W-1:0] xk;
  logic signed [OUT_W-1:0] xl;
  logic signed [OUT_W-1:0] xkl;

  assign x0  = $signed({{CW{1'b0}}, input_data});
  assign xk  = (warm_cnt >= k_r)    ? $signed({{CW{1'b0}}, mem[addr_k]})  : '0;
  assign xl  = (warm_cnt >= l_r)    ? $signed({{CW{1'b0}}, mem[addr_l]})  : '0;
  assign xkl = (warm_cnt >= kl_sum) ? $signed({{CW{1'b0}}, mem[addr_kl]}) : '0;

  // ---------------------------------------------------------------------------
  // Two-stage pipeline: stage 1 holds d(n) and the difference, stage 2 s(n)
  // ---------------------------------------------------------------------------
  logic                    v1;
  logic                    emit1;
  logic signed [OUT_W-1:0] d1;
  logic signed [OUT_W-1:0] diff1;
  logic signed [OUT_W-1:0] acc;
  logic signed [OUT_W-1:0] acc_nxt;

  assign acc_nxt = acc + d1;

  always_ff @(posedge clk) begin
    if (reset || cfg_accept) begin
      wr_ptr       <= '0;
      v1           <= 1'b0;
      emit1        <= 1'b0;
      d1           <= '0;
      diff1        <= '0;
      acc          <= '0;
      output_data  <= '0;
      output_valid <= 1'b0;
    end else begin
      v1           <= sample_ok;
      output_valid <= v1 && emit1;
      if (sample_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
        d1     <= x0 - xk - xl + xkl;
        diff1  <= x0 - xk;
        // Samples accepted during warm-up still feed the accumulator but are not emitted
        emit1  <= (state != WARMUP);
      end
      if (v1) begin
        acc         <= acc_nxt;
        output_data <= mode_r ? diff1 : acc_nxt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration, warm-up and peak tracking FSM
  // ---------------------------------------------------------------------------
  logic [TW-1:0]           time_cnt;
  logic [TW-1:0]           time_nxt;
  logic [TW-1:0]           max_idx;
  logic signed [OUT_W-1:0] peak_amp_r;

  assign time_nxt = (time_cnt == '1) ? time_cnt : time_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      k_r        <= CW'(K_DEF);
      l_r        <= CW'(L_DEF);
      mode_r     <= 1'b0;
      cfg_error  <= 1'b0;
      state      <= WARMUP;
      warm_cnt   <= '0;
      time_cnt   <= '0;
      max_idx    <= '0;
      peak_amp_r <= '0;
      peak_valid <= 1'b0;
      peak_amp   <= '0;
      peak_time  <= '0;
    end else begin
      peak_valid <= 1'b0;
      if (cfg_accept) begin
        // A pulse in progress is abandoned without a record
        k_r        <= cfg_k;
        l_r        <= cfg_l;
        mode_r     <= cfg_mode;
        cfg_error  <= 1'b0;
        state      <= WARMUP;
        warm_cnt   <= '0;
        time_cnt   <= '0;
        max_idx    <= '0;
        peak_amp_r <= '0;
      end else begin
        if (cfg_load) begin
          cfg_error <= 1'b1;
        end
        case (state)
          WARMUP: begin
            if (sample_ok) begin
              warm_cnt <= warm_cnt + 1'b1;
              if (warm_cnt + 1'b1 == kl_sum) begin
                state <= BELOW;
              end
            end
          end
          BELOW: begin
            if (output_valid && (output_data > threshold)) begin
              state      <= ABOVE;
              peak_amp_r <= output_data;
              time_cnt   <= '0;
              max_idx    <= '0;
            end
          end
          ABOVE: begin
            if (output_valid) begin
              if (output_data > threshold) begin
                time_cnt <= time_nxt;
                // Strictly greater: a repeated maximum keeps the earliest index
                if (output_data > peak_amp_r) begin
                  peak_amp_r <= output_data;
                  max_idx    <= time_nxt;
                end
              end else begin
                peak_valid <= 1'b1;
                peak_amp   <= peak_amp_r;
                peak_time  <= max_idx;
                state      <= BELOW;
              end
            end
          end
          default: state <= WARMUP;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shaper_filter.sv
// Bench for shaper_filter: directed stimulus against a window-sum model of the
// shaped stream plus a pulse model, checked every cycle, with literal anchors.
module tb_shaper_filter;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 32;
  localparam int CW     = 6;
  localparam int OUT_W  = 18;
  localparam int TW     = 10;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic [DATA_W-1:0]       input_data = '0;
  logic                    input_valid = 1'b0;
  logic                    cfg_load = 1'b0;
  logic [CW-1:0]           cfg_k = '0;
  logic [CW-1:0]           cfg_l = '0;
  logic                    cfg_mode = 1'b0;
  logic signed [OUT_W-1:0] threshold = '0;
  logic signed [OUT_W-1:0] output_data;
  logic                    output_valid;
  logic                    peak_valid;
  logic signed [OUT_W-1:0] peak_amp;
  logic [TW-1:0]           peak_time;
  logic                    cfg_error;

  shaper_filter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .K_DEF(4), .L_DEF(8)) dut (
    .clk(clk), .reset(reset),
    .input_data(input_data), .input_valid(input_valid),
    .cfg_load(cfg_load), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_mode(cfg_mode),
    .threshold(threshold),
    .output_data(output_data), .output_valid(output_valid),
    .peak_valid(peak_valid), .peak_amp(peak_amp), .peak_time(peak_time),
    .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct { int cyc; int val; } oev_t;
  typedef struct { int cyc; int amp; int tim; } pev_t;

  oev_t exp_q[$];
  pev_t pk_q[$];
  int   obs[$];
  int   pk_amp_log[$];
  int   pk_time_log[$];

  // Model state: samples since the last clear, active config, pulse tracking
  int hist[$];
  int mk = 4;
  int ml = 8;
  bit mmode = 1'b0;
  bit in_pulse = 1'b0;
  int pmax = 0;
  int pidx = 0;
  int pcnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int xat(input int j);
    return (j >= 1) ? hist[j-1] : 0;
  endfunction

  // s(n) equals the sum of the last K samples minus the sum of the K samples ending L earlier
  function automatic int model_out(input int n);
    int s = 0;
    if (mmode) return xat(n) - xat(n - mk);
    for (int i = 0; i < mk; i++) s += xat(n - i) - xat(n - ml - i);
    return s;
  endfunction

  task automatic peak_model(input int v, input int pc);
    int thr;
    pev_t p;
    thr = int'(threshold);
    if (!in_pulse) begin
      if (v > thr) begin
        in_pulse = 1'b1; pmax = v; pidx = 0; pcnt = 0;
      end
    end else if (v > thr) begin
      pcnt = (pcnt < 1023) ? pcnt + 1 : 1023;
      if (v > pmax) begin pmax = v; pidx = pcnt; end
    end else begin
      p.cyc = pc; p.amp = pmax; p.tim = pidx;
      pk_q.push_back(p);
      in_pulse = 1'b0;
    end
  endtask

  task automatic send(input int v);
    int n;
    int e;
    oev_t o;
    input_valid = 1'b1;
    input_data  = DATA_W'(v);
    @(posedge clk); #1;
    input_valid = 1'b0;
    hist.push_back(v);
    n = hist.size();
    if (n > mk + ml) begin
      e = model_out(n);
      o.cyc = cyc + 1; o.val = e;
      exp_q.push_back(o);
      peak_model(e, cyc + 2);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_gap(input int v);
    idle($urandom_range(0, 2));
    send(v);
  endtask

  task automatic do_cfg(input int k, input int l, input bit mode, input bit with_sample);
    bit ok;
    cfg_load    = 1'b1;
    cfg_k       = CW'(k);
    cfg_l       = CW'(l);
    cfg_mode    = mode;
    input_valid = with_sample;
    input_data  = 12'd4095;
    @(posedge clk); #1;
    cfg_load    = 1'b0;
    input_valid = 1'b0;
    ok = (k >= 1) && (k <= l) && (k + l <= DEPTH);
    if (ok) begin
      hist.delete(); mk = k; ml = l; mmode = mode; in_pulse = 1'b0;
    end
    check("cfg_error", int'(cfg_error), ok ? 0 : 1);
  endtask

  task automatic clear_logs();
    obs.delete(); pk_amp_log.delete(); pk_time_log.delete();
  endtask

  // Per-cycle comparison of the DUT against the model queues
  always @(negedge clk) begin : cmp
    oev_t e;
    pev_t p;
    if (!reset) begin
      if (output_valid) begin
        obs.push_back(int'(output_data));
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_unexpected: got %0d at cycle %0d expected no output", int'(output_data), cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.val != int'(output_data)) begin
            bad++;
            $display("FAIL out_data: got %0d at cycle %0d expected %0d at cycle %0d",
                     int'(output_data), cyc, e.val, e.cyc);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        total++; bad++;
        $display("FAIL out_missing: got no output at cycle %0d expected %0d", cyc, e.val);
      end

      if (peak_valid) begin
        pk_amp_log.push_back(int'(peak_amp));
        pk_time_log.push_back(int'(peak_time));
        total++;
        if (pk_q.size() == 0) begin
          bad++;
          $display("FAIL peak_unexpected: got amp=%0d time=%0d expected no peak", int'(peak_amp), int'(peak_time));
        end else begin
          p = pk_q.pop_front();
          if (p.cyc != cyc || p.amp != int'(peak_amp) || p.tim != int'(peak_time)) begin
            bad++;
            $display("FAIL peak: got amp=%0d time=%0d cycle=%0d expected amp=%0d time=%0d cycle=%0d",
                     int'(peak_amp), int'(peak_time), cyc, p.amp, p.tim, p.cyc);
          end
        end
      end else if (pk_q.size() != 0 && pk_q[0].cyc <= cyc) begin
        p = pk_q.pop_front();
        total++; bad++;
        $display("FAIL peak_missing: got none at cycle %0d expected amp=%0d time=%0d", cyc, p.amp, p.tim);
      end
    end
  end

  int step_lit[13] = '{100, 200, 300, 400, 400, 400, 400, 400, 300, 200, 100, 0, 0};
  int diff_lit[4]  = '{4095, 4095, 4095, 0};

  initial begin
    int mx;

    // Reset state
    reset = 1'b1;
    idle(2);
    check("rst_output_data", int'(output_data), 0);
    check("rst_output_valid", int'(output_valid), 0);
    check("rst_peak_valid", int'(peak_valid), 0);
    check("rst_peak_amp", int'(peak_amp), 0);
    check("rst_peak_time", int'(peak_time), 0);
    check("rst_cfg_error", int'(cfg_error), 0);
    reset = 1'b0;
    threshold = 18'sd250;

    // Step 0 -> 100 with the reset defaults K=4, L=8
    clear_logs();
    for (int i = 0; i < 12; i++) send(0);
    for (int i = 0; i < 20; i++) send(100);
    idle(4);
    check("step_count", obs.size(), 20);
    if (obs.size() >= 13)
      for (int i = 0; i < 13; i++) check("step_out", obs[i], step_lit[i]);
    check("step_npeaks", pk_amp_log.size(), 1);
    if (pk_amp_log.size() >= 1) begin
      check("step_peak_amp", pk_amp_log[0], 400);
      check("step_peak_time", pk_time_log[0], 1);
    end
    idle(3);
    check("step_peak_amp_hold", int'(peak_amp), 400);
    check("step_peak_time_hold", int'(peak_time), 1);

    // Constant baseline of 1000 through warm-up
    do_cfg(4, 8, 1'b0, 1'b0);
    clear_logs();
    for (int i = 0; i < 20; i++) send(1000);
    idle(4);
    check("base_count", obs.size(), 8);
    check("base_npeaks", pk_amp_log.size(), 0);

    // Accepted then rejected configuration; K/L must stay 10/20
    do_cfg(10, 20, 1'b0, 1'b0);
    do_cfg(9, 5, 1'b0, 1'b0);
    clear_logs();
    for (int i = 0; i < 30; i++) send(0);
    for (int i = 0; i < 40; i++) send(50);
    idle(4);
    check("k10_npeaks", pk_amp_log.size(), 1);
    if (pk_amp_log.size() >= 1) begin
      check("k10_peak_amp", pk_amp_log[0], 500);
      check("k10_peak_time", pk_time_log[0], 4);
    end
    check("k10_cfg_error_sticky", int'(cfg_error), 1);

    // Difference mode K=3; the sample coinciding with cfg_load is dropped
    threshold = 18'sd1000;
    do_cfg(3, 8, 1'b1, 1'b1);
    clear_logs();
    for (int i = 0; i < 11; i++) send(0);
    for (int i = 0; i < 8; i++) send(4095);
    idle(4);
    if (obs.size() >= 4)
      for (int i = 0; i < 4; i++) check("diff_out", obs[i], diff_lit[i]);
    else
      check("diff_count", obs.size(), 8);

    // Full-scale step with K=L=16: flat top at 16*4095
    threshold = 18'sd60000;
    do_cfg(16, 16, 1'b0, 1'b0);
    clear_logs();
    for (int i = 0; i < 32; i++) send(0);
    for (int i = 0; i < 40; i++) send(4095);
    idle(4);
    mx = -1;
    foreach (obs[i]) if (obs[i] > mx) mx = obs[i];
    check("k16_max", mx, 65520);
    check("k16_npeaks", pk_amp_log.size(), 1);
    if (pk_amp_log.size() >= 1) begin
      check("k16_peak_amp", pk_amp_log[0], 65520);
      check("k16_peak_time", pk_time_log[0], 1);
    end

    // Randomly gapped input; the model is gap-free by construction
    threshold = 18'sd250;
    do_cfg(5, 7, 1'b0, 1'b0);
    clear_logs();
    for (int i = 0; i < 12; i++) send_gap(0);
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 14; i++) send_gap((p == 0) ? 80 : (p == 1) ? 200 : 37);
      for (int i = 0; i < 14; i++) send_gap(0);
    end
    idle(4);
    check("gap_npeaks", pk_amp_log.size(), 2);

    // cfg_load in the middle of a pulse: no record, warm-up restarts
    do_cfg(4, 8, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) send(0);
    for (int i = 0; i < 6; i++) send(200);
    idle(3);
    clear_logs();
    do_cfg(4, 8, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) send(300);
    check("midcfg_warmup_quiet", obs.size(), 0);
    for (int i = 0; i < 2; i++) send(300);
    idle(4);
    check("midcfg_npeaks", pk_amp_log.size(), 0);

    // Reset in the middle of a pulse
    for (int i = 0; i < 6; i++) send(800);
    idle(2);
    clear_logs();
    reset = 1'b1;
    idle(1);
    hist.delete(); mk = 4; ml = 8; mmode = 1'b0; in_pulse = 1'b0;
    check("midrst_output_valid", int'(output_valid), 0);
    check("midrst_peak_amp", int'(peak_amp), 0);
    reset = 1'b0;
    idle(5);
    check("midrst_npeaks", pk_amp_log.size(), 0);
    for (int i = 0; i < 13; i++) send(0);
    idle(4);
    check("midrst_count", obs.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
